sd_data_xfer_ctrl: RTL and testbench

Multi-block data-transfer sequencer for the SD host data path. Accepts one read or write request of N blocks and drives `sd_data_serial_host` one block at a time via `start_dat` / `transm_complete` / `ack_transfer`. Gates each block on FIFO readiness and the card busy line, checks per-block CRC status, enforces a per-block timeout, and reports a single completion status. Sits between the command/register layer and `sd_data_serial_host`, in the `sd_clk` domain.

---
 rtl/sd_data_xfer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sd_data_xfer_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_xfer_ctrl.sv
// sd_data_xfer_ctrl: multi-block SD data-transfer sequencer in front of sd_data_serial_host.
// Defining SD_DATA_RETRY_EN builds per-block CRC retry; otherwise a bad CRC ends the request.
module sd_data_xfer_ctrl #(
  parameter int BLK_CNT_W   = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [BLK_CNT_W-1:0] req_blk_cnt,
  output logic                 req_ready,
  input  logic                 abort,
  input  logic                 tx_blk_avail,
  input  logic                 rx_blk_space,
  input  logic                 busy_n,
  input  logic                 transm_complete,
  input  logic                 crc_ok,
  output logic [1:0]           start_dat,
  output logic                 ack_transfer,
  output logic                 blk_retry,
  output logic [BLK_CNT_W-1:0] blk_done_cnt,
  output logic                 done,
  output logic [1:0]           status
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_XFER, S_ACK, S_CHECK, S_DONE
  } state_t;

  state_t               state, nxt;
  logic                 wr_q;
  logic [BLK_CNT_W-1:0] blk_cnt_q;
  logic [TMR_W-1:0]     timer;
  logic                 crc_q, tmo_q, abort_pend;
  logic [1:0]           done_status;
  logic                 gate_ok, last_blk, tmo_hit, retry_now;
  logic [BLK_CNT_W-1:0] cnt_inc;
  logic                 req_ready_d, ack_d, done_d;
  logic [1:0]           start_dat_d;

  assign gate_ok  = busy_n && (wr_q ? tx_blk_avail : rx_blk_space);
  assign cnt_inc  = blk_done_cnt + BLK_CNT_W'(1);
  assign last_blk = (cnt_inc == blk_cnt_q);
  // Timer reaches TIMEOUT_CYC on the same edge that leaves XFER.
  assign tmo_hit  = (timer == TMR_W'(TIMEOUT_CYC - 1));

`ifdef SD_DATA_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] retry_cnt;

  assign retry_now = !tmo_q && !crc_q && (retry_cnt < RTY_W'(MAX_RETRY));

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      retry_cnt <= '0;
      blk_retry <= 1'b0;
    end else begin
      blk_retry <= (nxt == S_CHECK) && retry_now;
      if (state == S_IDLE && req_valid) begin
        retry_cnt <= '0;
      end else if (state == S_CHECK && !tmo_q) begin
        if (crc_q)          retry_cnt <= '0;
        else if (retry_now) retry_cnt <= retry_cnt + RTY_W'(1);
      end
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
  assign retry_now = 1'b0;
  assign blk_retry = 1'b0;
`endif

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      start_dat    <= 2'b00;
      ack_transfer <= 1'b0;
      done         <= 1'b0;
      status       <= 2'b00;
      blk_done_cnt <= '0;
      wr_q         <= 1'b0;
      blk_cnt_q    <= '0;
      timer        <= '0;
      crc_q        <= 1'b0;
      tmo_q        <= 1'b0;
      abort_pend   <= 1'b0;
    end else begin
      state        <= nxt;
      req_ready    <= req_ready_d;
      start_dat    <= start_dat_d;
      ack_transfer <= ack_d;
      done         <= done_d;
      if (nxt == S_DONE) status <= done_status;
      if (state == S_IDLE && req_valid) begin
        wr_q         <= req_write;
        blk_cnt_q    <= req_blk_cnt;
        abort_pend   <= 1'b0;
        blk_done_cnt <= '0;
      end
      if (state == S_CHECK && crc_q && !tmo_q) blk_done_cnt <= cnt_inc;
      if (state == S_START) begin
        timer <= '0;
        crc_q <= 1'b0;
        tmo_q <= 1'b0;
      end
      if (state == S_XFER) begin
        if (timer != TMR_W'(TIMEOUT_CYC)) timer <= timer + TMR_W'(1);
        if (abort) abort_pend <= 1'b1;
        if (transm_complete) crc_q <= crc_ok;
        else if (tmo_hit)    tmo_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt         = state;
    done_status = 2'b00;
    case (state)
      S_IDLE:
        if (req_valid) begin
          if (req_blk_cnt == '0) begin
            nxt         = S_DONE;
            done_status = 2'b11;
          end else begin
            nxt = S_WAIT;
          end
        end
      S_WAIT:
        if (abort) begin
          nxt         = S_DONE;
          done_status = 2'b11;
        end else if (gate_ok) begin
          nxt = S_START;
        end
      S_START: nxt = S_XFER;
      S_XFER:  if (transm_complete || tmo_hit) nxt = S_ACK;
      S_ACK:   if (!transm_complete) nxt = S_CHECK;
      S_CHECK:
        if (tmo_q) begin
          nxt         = S_DONE;
          done_status = 2'b10;
        end else if (crc_q) begin
          if (last_blk) begin
            nxt = S_DONE;
          end else if (abort_pend) begin
            nxt         = S_DONE;
            done_status = 2'b11;
          end else begin
            nxt = S_WAIT;
          end
        end else if (retry_now) begin
          nxt = S_WAIT;
        end else begin
          nxt         = S_DONE;
          done_status = 2'b01;
        end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with the state.
  always_comb begin
    req_ready_d = (nxt == S_IDLE);
    ack_d       = (nxt == S_ACK);
    done_d      = (nxt == S_DONE);
    start_dat_d = 2'b00;
    if (nxt == S_START) start_dat_d = wr_q ? 2'b01 : 2'b10;
  end
endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Self-checking bench for sd_data_xfer_ctrl: directed vector table, hand sequences, and
// randomized transfers scored against a block-level model of the sequencing rules.
module tb_sd_data_xfer_ctrl;
  localparam int TMO = 100;
  localparam int MAXR = 3;
`ifdef SD_DATA_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        sd_clk = 1'b0;
  logic        rst, req_valid, req_write, abort, tx_blk_avail, rx_blk_space, busy_n;
  logic        transm_complete, crc_ok;
  logic [15:0] req_blk_cnt;
  logic        req_ready, ack_transfer, blk_retry, done;
  logic [1:0]  start_dat, status;
  logic [15:0] blk_done_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 sd_clk = ~sd_clk;

  sd_data_xfer_ctrl #(.BLK_CNT_W(16), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .sd_clk(sd_clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_blk_cnt(req_blk_cnt), .req_ready(req_ready), .abort(abort),
    .tx_blk_avail(tx_blk_avail), .rx_blk_space(rx_blk_space), .busy_n(busy_n),
    .transm_complete(transm_complete), .crc_ok(crc_ok), .start_dat(start_dat),
    .ack_transfer(ack_transfer), .blk_retry(blk_retry), .blk_done_cnt(blk_done_cnt),
    .done(done), .status(status)
  );

  typedef struct {
    bit          wr;
    int          cnt;
    logic [31:0] mask;     // bit a set: attempt a returns bad CRC
    int          tmo_a;    // attempt that never completes (-1 none)
    int          abort_a;  // attempt during whose XFER abort pulses (-1 none)
    int          e_st, e_cnt, e_starts, e_rty;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block-level outcome of one request, walked attempt by attempt.
  function automatic void model(input int cnt, input logic [31:0] mask, input int tmo_a,
                                input int abort_a, output int st, output int dcnt,
                                output int starts, output int retries);
    int rty;
    bit pend;
    st = 3; dcnt = 0; starts = 0; retries = 0; rty = 0; pend = 0;
    if (cnt == 0) return;
    for (int a = 0; a < 32; a++) begin
      starts++;
      if (a == abort_a) pend = 1;
      if (a == tmo_a) begin st = 2; return; end
      if (!mask[a]) begin
        dcnt++;
        rty = 0;
        if (dcnt == cnt) begin st = 0; return; end
        if (pend) begin st = 3; return; end
      end else if (RETRY && rty < MAXR) begin
        rty++;
        retries++;
      end else begin
        st = 1;
        return;
      end
    end
  endfunction

  task automatic drive_gate(input bit rnd, input bit wr, input int k, input int hold,
                            output bit gate);
    if (rnd) begin
      busy_n       = ($urandom_range(0, 3) != 0);
      tx_blk_avail = ($urandom_range(0, 3) != 0);
      rx_blk_space = ($urandom_range(0, 3) != 0);
    end else begin
      busy_n       = 1'b1;
      tx_blk_avail = (k >= hold - 1);
      rx_blk_space = (k >= hold - 1);
    end
    gate = busy_n && (wr ? tx_blk_avail : rx_blk_space);
  endtask

  task automatic run_xfer(input bit wr, input int cnt, input logic [31:0] mask,
                          input int tmo_a, input int abort_a, input bit rnd, input int hold,
                          output int st, output int dcnt, output int starts,
                          output int retries);
    int  a, cur_a, phase, start_c, raise_c, drop_c, hold_x, lat;
    bit  prev_gate, prev_start, prev_retry, got_done;
    st = -1; dcnt = -1; starts = 0; retries = 0; a = 0; cur_a = -1; phase = 0;
    start_c = -1000; raise_c = -1000; drop_c = -1000; hold_x = 0; lat = -1;
    prev_start = 0; prev_retry = 0; got_done = 0;
    @(negedge sd_clk);
    check("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_blk_cnt = 16'(cnt);
    drive_gate(rnd, wr, -1, hold, prev_gate);
    for (int c = 0; c < 4000 && !got_done; c++) begin
      @(negedge sd_clk);
      // observe
      if (c == 0) check("req_ready_busy", int'(req_ready), 0);
      if (start_dat != 2'b00) begin
        check("start_code", int'(start_dat), wr ? 1 : 2);
        check("start_width", int'(prev_start), 0);
        check("start_gated", int'(prev_gate), 1);
        if (!rnd && starts == 0) check("first_start_latency", c, (hold == 0) ? 1 : hold);
        if (!rnd && starts > 0) check("inter_block_gap", c - drop_c, 3);
        cur_a = a; a++; starts++; start_c = c; phase = 1;
        lat = (cur_a == tmo_a) ? -1 : int'($urandom_range(1, 8));
      end
      prev_start = (start_dat != 2'b00);
      if (blk_retry) begin
        check("retry_width", int'(prev_retry), 0);
        retries++;
      end
      prev_retry = blk_retry;
      if (phase == 1 && ack_transfer) begin
        if (cur_a == tmo_a) begin
          check("timeout_ack_delay", c - start_c, TMO + 1);
          phase = 3;
        end else begin
          check("ack_before_complete", int'(ack_transfer), 0);
        end
      end else if (phase == 3) begin
        check("timeout_ack_width", int'(ack_transfer), 0);
        phase = 0;
      end
      if (phase == 2 && c == raise_c + 1) check("ack_rise", int'(ack_transfer), 1);
      if (phase == 4 && c == drop_c + 1) begin
        check("ack_fall", int'(ack_transfer), 0);
        phase = 0;
      end
      if (done) begin
        st = int'(status); dcnt = int'(blk_done_cnt); got_done = 1;
        if (cnt == 0) check("illegal_done_latency", c, 0);
      end
      // drive
      drive_gate(rnd, wr, c, hold, prev_gate);
      req_valid = rnd && !got_done && ($urandom_range(0, 1) == 1);
      if (rnd) begin
        req_write   = ($urandom_range(0, 1) == 1);
        req_blk_cnt = 16'($urandom_range(0, 7));
      end
      abort = (cur_a == abort_a) && (c == start_c + 1);
      if (phase == 1 && c == start_c + lat) begin
        transm_complete = 1'b1;
        crc_ok = (cur_a < 32) ? !mask[cur_a] : 1'b1;
        raise_c = c; phase = 2; hold_x = $urandom_range(0, 2);
      end else if (phase == 2 && c == raise_c + 1 + hold_x) begin
        if (hold_x > 0) check("ack_hold", int'(ack_transfer), 1);
        transm_complete = 1'b0;
        crc_ok = ($urandom_range(0, 1) == 1);
        drop_c = c; phase = 4;
      end
    end
    check("done_seen", int'(got_done), 1);
    req_valid = 1'b0; abort = 1'b0; transm_complete = 1'b0;
    if (got_done) begin
      @(negedge sd_clk);
      check("done_width", int'(done), 0);
      check("req_ready_after_done", int'(req_ready), 1);
      check("status_hold", int'(status), st);
    end else begin
      rst = 1'b1;
      @(negedge sd_clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, dc, sn, rt, cnt, tmo_a, abort_a;
    int e_st, e_dc, e_sn, e_rt;
    bit wr;
    logic [31:0] mask;

    tbl[0] = '{1, 3, 32'h0, -1, -1, 0, 3, 3, 0};
    tbl[1] = '{0, 1, 32'h0, -1, -1, 0, 1, 1, 0};
    tbl[2] = '{1, 2, 32'h1, -1, -1, RETRY ? 0 : 1, RETRY ? 2 : 0, RETRY ? 3 : 1, RETRY ? 1 : 0};
    tbl[3] = '{1, 1, 32'h0, 0, -1, 2, 0, 1, 0};
    tbl[4] = '{0, 0, 32'h0, -1, -1, 3, 0, 0, 0};
    tbl[5] = '{1, 4, 32'h0, -1, 0, 3, 1, 1, 0};
    tbl[6] = '{0, 2, 32'h0, 1, -1, 2, 1, 2, 0};
    tbl[7] = '{1, 3, 32'hF, -1, -1, 1, 0, RETRY ? 4 : 1, RETRY ? 3 : 0};
    tbl[8] = '{0, 2, 32'h2, -1, -1, RETRY ? 0 : 1, RETRY ? 2 : 1, RETRY ? 3 : 2, RETRY ? 1 : 0};
    tbl[9] = '{1, 3, 32'h0, -1, 2, 0, 3, 3, 0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_blk_cnt = '0; abort = 1'b0;
    tx_blk_avail = 1'b1; rx_blk_space = 1'b1; busy_n = 1'b1;
    transm_complete = 1'b0; crc_ok = 1'b0;
    repeat (3) @(negedge sd_clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_start_dat", int'(start_dat), 0);
    check("rst_ack", int'(ack_transfer), 0);
    check("rst_retry", int'(blk_retry), 0);
    check("rst_done", int'(done), 0);
    check("rst_status", int'(status), 0);
    check("rst_blk_done_cnt", int'(blk_done_cnt), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_xfer(tbl[i].wr, tbl[i].cnt, tbl[i].mask, tbl[i].tmo_a, tbl[i].abort_a, 1'b0, 0,
               st, dc, sn, rt);
      check($sformatf("vec%0d_status", i), st, tbl[i].e_st);
      check($sformatf("vec%0d_blk_done_cnt", i), dc, tbl[i].e_cnt);
      check($sformatf("vec%0d_starts", i), sn, tbl[i].e_starts);
      check($sformatf("vec%0d_retries", i), rt, tbl[i].e_rty);
    end

    // Read held off by a full rx FIFO for 20+ cycles.
    run_xfer(1'b0, 1, 32'h0, -1, -1, 1'b0, 21, st, dc, sn, rt);
    check("gated_read_status", st, 0);
    check("gated_read_cnt", dc, 1);
    check("gated_read_starts", sn, 1);

    // Abort while parked in WAIT.
    @(negedge sd_clk);
    tx_blk_avail = 1'b0; rx_blk_space = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_blk_cnt = 16'd2;
    @(negedge sd_clk);
    req_valid = 1'b0; abort = 1'b1;
    @(negedge sd_clk);
    abort = 1'b0;
    check("wait_abort_done", int'(done), 1);
    check("wait_abort_status", int'(status), 3);
    check("wait_abort_cnt", int'(blk_done_cnt), 0);
    @(negedge sd_clk);

    // Synchronous reset while parked in WAIT.
    req_valid = 1'b1; req_write = 1'b1; req_blk_cnt = 16'd4;
    @(negedge sd_clk);
    req_valid = 1'b0;
    check("wait_req_ready", int'(req_ready), 0);
    rst = 1'b1;
    @(negedge sd_clk);
    rst = 1'b0;
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_start_dat", int'(start_dat), 0);
    check("midrst_ack", int'(ack_transfer), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_status", int'(status), 0);
    check("midrst_blk_done_cnt", int'(blk_done_cnt), 0);
    tx_blk_avail = 1'b1; rx_blk_space = 1'b1;

    for (int n = 0; n < 40; n++) begin
      wr      = ($urandom_range(0, 1) == 1);
      cnt     = $urandom_range(0, 5);
      mask    = $urandom & $urandom;
      tmo_a   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      abort_a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      model(cnt, mask, tmo_a, abort_a, e_st, e_dc, e_sn, e_rt);
      run_xfer(wr, cnt, mask, tmo_a, abort_a, 1'b1, 0, st, dc, sn, rt);
      check($sformatf("rnd%0d_status", n), st, e_st);
      check($sformatf("rnd%0d_blk_done_cnt", n), dc, e_dc);
      check($sformatf("rnd%0d_starts", n), sn, e_sn);
      check($sformatf("rnd%0d_retries", n), rt, e_rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
